// File: rtl/lucid64_obi_pkg.sv
// ---------------------------------------------------------------------------
// lucid64_obi_pkg
//   Shared OBI bus widths, host identifiers and the bundled address-phase
//   request type used by the OBI arbiter and its owner-ID FIFO.
// ---------------------------------------------------------------------------
package lucid64_obi_pkg;

  localparam int OBI_AW  = 64;
  localparam int OBI_DW  = 64;
  localparam int OBI_BEW = 8;

  // One bit is enough to name either of the two hosts.
  localparam int HOST_ID_W = 1;
  typedef logic [HOST_ID_W-1:0] host_id_t;

  localparam host_id_t HOST_DATA  = 1'b0;
  localparam host_id_t HOST_FETCH = 1'b1;

  // Address-phase payload of one host, muxed as a unit onto the device port.
  typedef struct packed {
    logic               we;
    logic [OBI_BEW-1:0] be;
    logic [OBI_AW-1:0]  addr;
    logic [OBI_DW-1:0]  wdata;
  } obi_req_t;

  // Width of a counter that must represent 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/obi_id_fifo.sv
// ---------------------------------------------------------------------------
// obi_id_fifo
//   Small synchronous FIFO used to remember which host owns each granted,
//   not-yet-answered read. Supports push and pop in the same cycle; pointers
//   wrap modulo DEPTH so any DEPTH (not only powers of two) works.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset (empties the FIFO)
//   push_i       write push_data_i at the tail
//   push_data_i  entry to store
//   pop_i        drop the head entry
//   head_o       oldest entry (valid when count_o != 0)
//   count_o      number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module obi_id_fifo
  import lucid64_obi_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 1
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        push_i,
  input  logic [WIDTH-1:0]            push_data_i,
  input  logic                        pop_i,
  output logic [WIDTH-1:0]            head_o,
  output logic [cnt_width(DEPTH)-1:0] count_o
);

  localparam int CNT_W = cnt_width(DEPTH);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // Pops on an empty FIFO are ignored; a push into a full FIFO is only
  // accepted when a pop frees the head in the same cycle.
  assign do_pop  = pop_i && (count != '0);
  assign do_push = push_i && ((count != CNT_W'(DEPTH)) || do_pop);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; validity is defined solely by the
  // pointers and count, so clearing the entries would only cost flops.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data_i;
  end

  assign head_o  = mem[rd_ptr];
  assign count_o = count;

endmodule

// File: rtl/obi_arbiter.sv
// ---------------------------------------------------------------------------
// obi_arbiter
//   Shares one 64-bit OBI device port between the data-side host (host 0)
//   and the fetch-side host (host 1). The address phase is purely
//   combinational: the selected host's request goes straight to the device
//   and the device grant goes straight back. A pending (requested but not
//   yet granted) selection is locked so the address phase stays stable.
//   Read responses are routed back in order via an owner-ID FIFO; writes
//   complete on grant and are never tracked.
//
// Parameters:
//   MAX_OUTSTANDING  granted reads that may await rvalid (1..4)
//   RR_EN            0: fixed priority, host 0 first; 1: round-robin
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   hN_req_i/we_i/be_i/addr_i/wdata_i   address phase from host N
//   hN_gnt_o                     grant to host N
//   hN_rvalid_o/hN_rdata_o       read response to host N (rdata 0 otherwise)
//   d_req_o/we_o/be_o/addr_o/wdata_o    address phase to the device
//   d_gnt_i                      device grant
//   d_rvalid_i/d_rdata_i         device read response
//   rsp_err_o                    sticky: rvalid seen with no read outstanding
// ---------------------------------------------------------------------------
module obi_arbiter
  import lucid64_obi_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int RR_EN           = 0
) (
  input  logic               clk_i,
  input  logic               rst_i,

  input  logic               h0_req_i,
  input  logic               h0_we_i,
  input  logic [OBI_BEW-1:0] h0_be_i,
  input  logic [OBI_AW-1:0]  h0_addr_i,
  input  logic [OBI_DW-1:0]  h0_wdata_i,
  output logic               h0_gnt_o,
  output logic               h0_rvalid_o,
  output logic [OBI_DW-1:0]  h0_rdata_o,

  input  logic               h1_req_i,
  input  logic               h1_we_i,
  input  logic [OBI_BEW-1:0] h1_be_i,
  input  logic [OBI_AW-1:0]  h1_addr_i,
  input  logic [OBI_DW-1:0]  h1_wdata_i,
  output logic               h1_gnt_o,
  output logic               h1_rvalid_o,
  output logic [OBI_DW-1:0]  h1_rdata_o,

  output logic               d_req_o,
  output logic               d_we_o,
  output logic [OBI_BEW-1:0] d_be_o,
  output logic [OBI_AW-1:0]  d_addr_o,
  output logic [OBI_DW-1:0]  d_wdata_o,
  input  logic               d_gnt_i,
  input  logic               d_rvalid_i,
  input  logic [OBI_DW-1:0]  d_rdata_i,

  output logic               rsp_err_o
);

  localparam int CNT_W = cnt_width(MAX_OUTSTANDING);

  // ---------------------------------------------------------------------
  // Host request bundling
  // ---------------------------------------------------------------------
  logic [1:0] req;
  obi_req_t   host_req [2];
  obi_req_t   dev_req;

  assign req         = {h1_req_i, h0_req_i};
  assign host_req[0] = '{we: h0_we_i, be: h0_be_i, addr: h0_addr_i, wdata: h0_wdata_i};
  assign host_req[1] = '{we: h1_we_i, be: h1_be_i, addr: h1_addr_i, wdata: h1_wdata_i};

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic       lock_vld;
  host_id_t   lock_id;
  host_id_t   rr_last;
  logic       rsp_err;

  logic [CNT_W-1:0] count;
  host_id_t         head;

  // ---------------------------------------------------------------------
  // Selection and address phase
  // ---------------------------------------------------------------------
  host_id_t sel;
  host_id_t mux_sel;
  logic     can_issue;
  logic     accept;
  logic     push;
  logic     pop;

  // Registered count only: a response popping this cycle does not make room
  // for a new request until the next cycle.
  assign can_issue = (count < CNT_W'(MAX_OUTSTANDING));

  // NOTE: every always_comb output gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    sel = HOST_DATA;
    if (lock_vld) begin
      sel = lock_id;
    end else begin
      case (req)
        2'b01:   sel = HOST_DATA;
        2'b10:   sel = HOST_FETCH;
        2'b11:   sel = (RR_EN != 0) ? ~rr_last : HOST_DATA;
        default: sel = HOST_DATA;
      endcase
    end
  end

  assign d_req_o = can_issue && req[sel];

  // Payload fields are don't-care without a request; tie them to host 0 so
  // the device port does not toggle with an unselected host's bus.
  assign mux_sel = d_req_o ? sel : HOST_DATA;
  assign dev_req = host_req[mux_sel];

  assign d_we_o    = dev_req.we;
  assign d_be_o    = dev_req.be;
  assign d_addr_o  = dev_req.addr;
  assign d_wdata_o = dev_req.wdata;

  assign accept   = d_req_o && d_gnt_i;
  assign h0_gnt_o = accept && (sel == HOST_DATA);
  assign h1_gnt_o = accept && (sel == HOST_FETCH);

  // ---------------------------------------------------------------------
  // Response routing
  // ---------------------------------------------------------------------
  assign push = accept && !d_we_o;
  assign pop  = d_rvalid_i && (count != '0);

  assign h0_rvalid_o = pop && (head == HOST_DATA);
  assign h1_rvalid_o = pop && (head == HOST_FETCH);
  assign h0_rdata_o  = h0_rvalid_o ? d_rdata_i : '0;
  assign h1_rdata_o  = h1_rvalid_o ? d_rdata_i : '0;

  obi_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (HOST_ID_W)
  ) u_id_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_data_i (sel),
    .pop_i       (pop),
    .head_o      (head),
    .count_o     (count)
  );

  // ---------------------------------------------------------------------
  // Lock, round-robin history and error flag
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_vld <= 1'b0;
      lock_id  <= HOST_DATA;
      rr_last  <= HOST_FETCH;   // host 0 wins the first round-robin tie
      rsp_err  <= 1'b0;
    end else begin
      // Lock while the device stalls the request, and also while the
      // outstanding limit blocks it, so the chosen host goes first once a
      // slot frees. A granted request releases the lock.
      if (accept) begin
        lock_vld <= 1'b0;
      end else if (d_req_o || (!can_issue && (req != 2'b00))) begin
        lock_vld <= 1'b1;
        lock_id  <= sel;
      end

      if (accept && (RR_EN != 0)) rr_last <= sel;

      if (d_rvalid_i && (count == '0)) rsp_err <= 1'b1;
    end
  end

  assign rsp_err_o = rsp_err;

endmodule

// File: tb/tb_obi_arbiter.sv
// ---------------------------------------------------------------------------
// tb_obi_arbiter
//   Directed bench for obi_arbiter. Two instances share all inputs: dut0
//   uses fixed priority and dut1 round-robin. The stimulus pushes expected
//   device accepts and host responses into queues; a monitor on the falling
//   edge pops and compares whenever the observed instance shows an accept or
//   a host rvalid. A few cycle-specific properties are checked inline.
// ---------------------------------------------------------------------------
module tb_obi_arbiter;

  logic clk;
  logic rst;

  logic        h0_req, h0_we, h1_req, h1_we;
  logic [7:0]  h0_be, h1_be;
  logic [63:0] h0_addr, h0_wdata, h1_addr, h1_wdata;
  logic        d_gnt, d_rvalid;
  logic [63:0] d_rdata;

  // dut0 outputs
  logic        o0_h0_gnt, o0_h0_rvalid, o0_h1_gnt, o0_h1_rvalid;
  logic [63:0] o0_h0_rdata, o0_h1_rdata;
  logic        o0_d_req, o0_d_we, o0_rsp_err;
  logic [7:0]  o0_d_be;
  logic [63:0] o0_d_addr, o0_d_wdata;

  // dut1 outputs
  logic        o1_h0_gnt, o1_h0_rvalid, o1_h1_gnt, o1_h1_rvalid;
  logic [63:0] o1_h0_rdata, o1_h1_rdata;
  logic        o1_d_req, o1_d_we, o1_rsp_err;
  logic [7:0]  o1_d_be;
  logic [63:0] o1_d_addr, o1_d_wdata;

  obi_arbiter #(.MAX_OUTSTANDING(2), .RR_EN(0)) dut0 (
    .clk_i(clk), .rst_i(rst),
    .h0_req_i(h0_req), .h0_we_i(h0_we), .h0_be_i(h0_be), .h0_addr_i(h0_addr),
    .h0_wdata_i(h0_wdata), .h0_gnt_o(o0_h0_gnt), .h0_rvalid_o(o0_h0_rvalid),
    .h0_rdata_o(o0_h0_rdata),
    .h1_req_i(h1_req), .h1_we_i(h1_we), .h1_be_i(h1_be), .h1_addr_i(h1_addr),
    .h1_wdata_i(h1_wdata), .h1_gnt_o(o0_h1_gnt), .h1_rvalid_o(o0_h1_rvalid),
    .h1_rdata_o(o0_h1_rdata),
    .d_req_o(o0_d_req), .d_we_o(o0_d_we), .d_be_o(o0_d_be), .d_addr_o(o0_d_addr),
    .d_wdata_o(o0_d_wdata), .d_gnt_i(d_gnt), .d_rvalid_i(d_rvalid),
    .d_rdata_i(d_rdata), .rsp_err_o(o0_rsp_err)
  );

  obi_arbiter #(.MAX_OUTSTANDING(2), .RR_EN(1)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .h0_req_i(h0_req), .h0_we_i(h0_we), .h0_be_i(h0_be), .h0_addr_i(h0_addr),
    .h0_wdata_i(h0_wdata), .h0_gnt_o(o1_h0_gnt), .h0_rvalid_o(o1_h0_rvalid),
    .h0_rdata_o(o1_h0_rdata),
    .h1_req_i(h1_req), .h1_we_i(h1_we), .h1_be_i(h1_be), .h1_addr_i(h1_addr),
    .h1_wdata_i(h1_wdata), .h1_gnt_o(o1_h1_gnt), .h1_rvalid_o(o1_h1_rvalid),
    .h1_rdata_o(o1_h1_rdata),
    .d_req_o(o1_d_req), .d_we_o(o1_d_we), .d_be_o(o1_d_be), .d_addr_o(o1_d_addr),
    .d_wdata_o(o1_d_wdata), .d_gnt_i(d_gnt), .d_rvalid_i(d_rvalid),
    .d_rdata_i(d_rdata), .rsp_err_o(o1_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------
  // Counters and check helpers
  // ---------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic got, input logic exp);
    check(name, 64'(got), 64'(exp));
  endtask

  task automatic flag_fail(input string name, input logic [63:0] got);
    total++;
    bad++;
    $display("FAIL %s: got=%h expected=nothing (t=%0t)", name, got, $time);
  endtask

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  typedef struct {
    logic        host;
    logic        we;
    logic [7:0]  be;
    logic [63:0] addr;
    logic [63:0] wdata;
  } acc_t;

  typedef struct {
    logic        host;
    logic [63:0] data;
  } rsp_t;

  acc_t acc_q[$];
  rsp_t rsp_q[$];
  logic mon_sel = 1'b0;   // 0: observe dut0, 1: observe dut1

  task automatic exp_acc(input logic host, input logic we, input logic [7:0] be,
                         input logic [63:0] addr, input logic [63:0] wdata);
    acc_q.push_back('{host: host, we: we, be: be, addr: addr, wdata: wdata});
  endtask

  task automatic exp_rsp(input logic host, input logic [63:0] data);
    rsp_q.push_back('{host: host, data: data});
  endtask

  logic        m_req, m_gnt0, m_gnt1, m_we, m_rv0, m_rv1;
  logic [7:0]  m_be;
  logic [63:0] m_addr, m_wdata, m_rd0, m_rd1;

  assign m_req   = mon_sel ? o1_d_req     : o0_d_req;
  assign m_gnt0  = mon_sel ? o1_h0_gnt    : o0_h0_gnt;
  assign m_gnt1  = mon_sel ? o1_h1_gnt    : o0_h1_gnt;
  assign m_we    = mon_sel ? o1_d_we      : o0_d_we;
  assign m_be    = mon_sel ? o1_d_be      : o0_d_be;
  assign m_addr  = mon_sel ? o1_d_addr    : o0_d_addr;
  assign m_wdata = mon_sel ? o1_d_wdata   : o0_d_wdata;
  assign m_rv0   = mon_sel ? o1_h0_rvalid : o0_h0_rvalid;
  assign m_rv1   = mon_sel ? o1_h1_rvalid : o0_h1_rvalid;
  assign m_rd0   = mon_sel ? o1_h0_rdata  : o0_h0_rdata;
  assign m_rd1   = mon_sel ? o1_h1_rdata  : o0_h1_rdata;

  acc_t mon_a;
  rsp_t mon_r;

  always @(negedge clk) begin
    if (!rst) begin
      if (m_req && d_gnt) begin
        if (acc_q.size() == 0) begin
          flag_fail("accept_unexpected", m_addr);
        end else begin
          mon_a = acc_q.pop_front();
          check("acc_gnt", 64'({m_gnt1, m_gnt0}), mon_a.host ? 64'h2 : 64'h1);
          check("acc_addr", m_addr, mon_a.addr);
          check1("acc_we", m_we, mon_a.we);
          check("acc_be", 64'(m_be), 64'(mon_a.be));
          check("acc_wdata", m_wdata, mon_a.wdata);
        end
      end else if (m_gnt0 || m_gnt1) begin
        flag_fail("gnt_without_accept", 64'({m_gnt1, m_gnt0}));
      end

      if (m_rv0 || m_rv1) begin
        if (rsp_q.size() == 0) begin
          flag_fail("rvalid_unexpected", 64'({m_rv1, m_rv0}));
        end else begin
          mon_r = rsp_q.pop_front();
          check("rsp_owner", 64'({m_rv1, m_rv0}), mon_r.host ? 64'h2 : 64'h1);
          check("rsp_data", mon_r.host ? m_rd1 : m_rd0, mon_r.data);
          check("rsp_other_zero", mon_r.host ? m_rd0 : m_rd1, 64'h0);
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    h0_req = 0; h0_we = 0; h0_be = 8'h00; h0_addr = '0; h0_wdata = '0;
    h1_req = 0; h1_we = 0; h1_be = 8'h00; h1_addr = '0; h1_wdata = '0;
    d_gnt = 0; d_rvalid = 0; d_rdata = '0;
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    idle();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic h0_read(input logic [63:0] addr);
    h0_req = 1; h0_we = 0; h0_be = 8'hFF; h0_addr = addr; h0_wdata = '0;
  endtask

  task automatic h1_read(input logic [63:0] addr);
    h1_req = 1; h1_we = 0; h1_be = 8'hFF; h1_addr = addr; h1_wdata = '0;
  endtask

  // Global safety net: the directed sequence is short and never waits on
  // the DUT, so this only fires if the bench itself is broken.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    idle();
    do_reset();

    // Reset state with idle hosts.
    @(negedge clk);
    check1("rst_d_req", o0_d_req, 1'b0);
    check1("rst_h0_gnt", o0_h0_gnt, 1'b0);
    check1("rst_h1_gnt", o0_h1_gnt, 1'b0);
    check1("rst_h0_rvalid", o0_h0_rvalid, 1'b0);
    check1("rst_h1_rvalid", o0_h1_rvalid, 1'b0);
    check1("rst_rsp_err", o0_rsp_err, 1'b0);
    check1("rst_rr_d_req", o1_d_req, 1'b0);

    // --- Fixed priority, both reading, device grants every cycle ---
    mon_sel = 1'b0;
    step();
    h0_read(64'h100);
    h1_read(64'h200);
    d_gnt = 1;
    exp_acc(1'b0, 1'b0, 8'hFF, 64'h100, 64'h0);
    step();
    h0_req = 0;
    exp_acc(1'b1, 1'b0, 8'hFF, 64'h200, 64'h0);
    step();
    h1_req = 0;
    d_gnt = 0;
    d_rvalid = 1;
    d_rdata = 64'hA5A5_0000_0000_0001;
    exp_rsp(1'b0, 64'hA5A5_0000_0000_0001);
    step();
    d_rdata = 64'h0000_0000_DEAD_BEEF;
    exp_rsp(1'b1, 64'h0000_0000_DEAD_BEEF);
    step();
    d_rvalid = 0;
    step();

    // --- Round-robin, both writing continuously, gnt held high ---
    do_reset();
    mon_sel = 1'b1;
    h0_req = 1; h0_we = 1; h0_be = 8'hFF; h0_addr = 64'h1000; h0_wdata = 64'hAAAA;
    h1_req = 1; h1_we = 1; h1_be = 8'hFF; h1_addr = 64'h2000; h1_wdata = 64'hBBBB;
    d_gnt = 1;
    for (int i = 0; i < 4; i++) begin
      logic hh;
      hh = 1'(i % 2);
      exp_acc(hh, 1'b1, 8'hFF, hh ? 64'h2000 : 64'h1000, hh ? 64'hBBBB : 64'hAAAA);
      step();
    end
    idle();
    step();
    mon_sel = 1'b0;

    // --- Stalled grant: selection stays on host 0 ---
    do_reset();
    h0_read(64'h80);
    for (int c = 0; c < 4; c++) begin
      if (c == 2) h1_read(64'h300);
      if (c == 3) begin
        d_gnt = 1;
        exp_acc(1'b0, 1'b0, 8'hFF, 64'h80, 64'h0);
      end
      @(negedge clk);
      check("stall_addr", o0_d_addr, 64'h80);
      check1("stall_d_req", o0_d_req, 1'b1);
      check1("stall_h1_gnt", o0_h1_gnt, 1'b0);
      step();
    end
    h0_req = 0;
    exp_acc(1'b1, 1'b0, 8'hFF, 64'h300, 64'h0);
    @(negedge clk);
    check1("stall_h1_gnt_after", o0_h1_gnt, 1'b1);
    step();
    idle();
    step();

    // --- Lock on host 1 survives a later host-0 request ---
    do_reset();
    h1_read(64'h400);
    @(negedge clk);
    check("lock_addr_first", o0_d_addr, 64'h400);
    step();
    h0_read(64'h500);
    @(negedge clk);
    check("lock_addr_held", o0_d_addr, 64'h400);
    check1("lock_d_req", o0_d_req, 1'b1);
    step();
    d_gnt = 1;
    exp_acc(1'b1, 1'b0, 8'hFF, 64'h400, 64'h0);
    step();
    h1_req = 0;
    exp_acc(1'b0, 1'b0, 8'hFF, 64'h500, 64'h0);
    step();
    idle();
    step();

    // --- Outstanding limit: third read waits for a response ---
    do_reset();
    h0_read(64'h10);
    d_gnt = 1;
    exp_acc(1'b0, 1'b0, 8'hFF, 64'h10, 64'h0);
    step();
    h0_addr = 64'h18;
    exp_acc(1'b0, 1'b0, 8'hFF, 64'h18, 64'h0);
    step();
    h0_addr = 64'h20;
    @(negedge clk);
    check1("limit_d_req_full", o0_d_req, 1'b0);
    check1("limit_h0_gnt_full", o0_h0_gnt, 1'b0);
    step();
    d_rvalid = 1;
    d_rdata = 64'h111;
    exp_rsp(1'b0, 64'h111);
    @(negedge clk);
    check1("limit_d_req_same_pop", o0_d_req, 1'b0);
    step();
    d_rvalid = 0;
    exp_acc(1'b0, 1'b0, 8'hFF, 64'h20, 64'h0);
    @(negedge clk);
    check1("limit_d_req_freed", o0_d_req, 1'b1);
    step();
    idle();
    step();

    // --- Write is not tracked; following read owns the response ---
    do_reset();
    h1_req = 1; h1_we = 1; h1_be = 8'h0F; h1_addr = 64'h600; h1_wdata = 64'h1234_5678;
    d_gnt = 1;
    exp_acc(1'b1, 1'b1, 8'h0F, 64'h600, 64'h1234_5678);
    step();
    h1_req = 0; h1_we = 0;
    h0_read(64'h700);
    exp_acc(1'b0, 1'b0, 8'hFF, 64'h700, 64'h0);
    @(negedge clk);
    check("write_count", 64'(dut0.count), 64'h0);
    step();
    h0_req = 0;
    d_gnt = 0;
    d_rvalid = 1;
    d_rdata = 64'hCAFE;
    exp_rsp(1'b0, 64'hCAFE);
    @(negedge clk);
    check1("write_h1_rvalid", o0_h1_rvalid, 1'b0);
    check("write_h1_rdata", o0_h1_rdata, 64'h0);
    step();
    d_rvalid = 0;
    @(negedge clk);
    check1("write_rsp_err", o0_rsp_err, 1'b0);
    step();

    // --- Unsolicited rvalid sets the sticky error; reset clears it ---
    do_reset();
    d_rvalid = 1;
    d_rdata = 64'hFFFF;
    @(negedge clk);
    check1("err_h0_rvalid", o0_h0_rvalid, 1'b0);
    check1("err_h1_rvalid", o0_h1_rvalid, 1'b0);
    check1("err_not_yet", o0_rsp_err, 1'b0);
    step();
    d_rvalid = 0;
    @(negedge clk);
    check1("err_set", o0_rsp_err, 1'b1);
    step();
    @(negedge clk);
    check1("err_sticky", o0_rsp_err, 1'b1);
    rst = 1'b1;
    step();
    @(negedge clk);
    check1("err_cleared", o0_rsp_err, 1'b0);
    rst = 1'b0;
    step();
    step();

    // Every expected accept and response must have been observed.
    check("acc_queue_drained", 64'(acc_q.size()), 64'h0);
    check("rsp_queue_drained", 64'(rsp_q.size()), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/obi_arbiter.md
Name: obi_arbiter

Overview:
- Shares one 64-bit OBI device port between two hosts: host 0 is the data-side obi_host_driver and host 1 is the fetch-side obi_host_driver.
- Arbitrates address phases, holds the selection stable until the device grants, and routes read responses back to the issuing host.
- Response routing uses an in-order owner-ID FIFO.
- Sits between the core's two host drivers and the single memory or bus port.

Parameters:
- MAX_OUTSTANDING, 2: maximum granted reads awaiting rvalid. Legal range is 1..4.
- RR_EN, 0: arbitration mode. 0 = fixed priority with host 0 first. 1 = round-robin.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- h0_req_i  in  1  host 0 request
- h0_we_i  in  1  host 0 write enable
- h0_be_i  in  8  host 0 byte enables
- h0_addr_i  in  64  host 0 address
- h0_wdata_i  in  64  host 0 write data
- h0_gnt_o  out  1  host 0 grant
- h0_rvalid_o  out  1  host 0 read response valid
- h0_rdata_o  out  64  host 0 read data
- h1_req_i, h1_we_i, h1_be_i, h1_addr_i, h1_wdata_i, h1_gnt_o, h1_rvalid_o, h1_rdata_o: same as host 0, for host 1
- d_req_o  out  1  device request
- d_we_o  out  1  device write enable
- d_be_o  out  8  device byte enables
- d_addr_o  out  64  device address
- d_wdata_o  out  64  device write data
- d_gnt_i  in  1  device grant
- d_rvalid_i  in  1  device read response valid
- d_rdata_i  in  64  device read data
- rsp_err_o  out  1  sticky flag: rvalid arrived with no read outstanding

Behaviour:
- Timing: address phase is combinational and adds zero cycles. Response routing is combinational from d_rvalid_i, adding zero cycles.
- Read-only responses: devices return rvalid only for reads. Writes complete on gnt and are never pushed to the owner FIFO.
- State registers:
  - lock_vld and lock_id: pending-selection lock.
  - rr_last: last granted host, used when RR_EN=1.
  - Owner FIFO holding 1-bit IDs, with count.
- can_issue = (count < MAX_OUTSTANDING). This uses the registered count. A same-cycle pop does not free a slot.
- Selection:
  - If lock_vld, sel = lock_id.
  - Otherwise, with only one requester, sel is that requester.
  - With both requesting: RR_EN=0 gives sel = 0. RR_EN=1 gives sel = !rr_last.
- Outputs to device:
  - d_req_o = can_issue && req[sel].
  - d_we/be/addr/wdata mux from sel.
  - When d_req_o = 0, the muxed fields are don't-care, but drive them from host 0.
- Grants:
  - h{sel}_gnt_o = d_gnt_i && d_req_o.
  - The unselected host's gnt is 0.
- Lock:
  - When d_req_o && !d_gnt_i: lock_vld <= 1, lock_id <= sel.
  - When d_req_o && d_gnt_i: lock_vld <= 0.
  - When can_issue = 0 and a host is requesting, hold or establish the lock on the host that would have been selected, so that host is served first when a slot frees.
  - An OBI host never retracts req before gnt, so the lock never dangles.
- Accept (d_req_o && d_gnt_i):
  - If RR_EN, rr_last <= sel.
  - If !d_we_o, push sel into the FIFO.
- Response (d_rvalid_i):
  - With count > 0: route to head ID. hX_rvalid_o = 1 and hX_rdata_o = d_rdata_i for X = head; pop.
  - With count == 0: no host rvalid, and rsp_err_o <= 1.
  - rdata to the non-owning host is driven 0.
- Push and pop in the same cycle: count is unchanged. The head advances correctly, and the FIFO wraps modulo MAX_OUTSTANDING.
- Reset state: count = 0, FIFO pointers = 0, lock_vld = 0, lock_id = 0, rr_last = 1 (so host 0 wins first under RR), rsp_err_o = 0.
- Reset values of all combinational outputs follow from the reset state with the hosts idle: d_req_o = 0, both gnt = 0, both rvalid = 0.
- Reset mid-transaction: outstanding responses are discarded. Responses arriving after reset set rsp_err_o. The system must reset the device together with the arbiter.

Decomposition:
- Package lucid64_obi_pkg:
  - OBI_AW = 64, OBI_DW = 64, OBI_BEW = 8.
  - Host IDs: HOST_DATA = 0, HOST_FETCH = 1.
  - Host-ID width constant.
- Sub-module obi_id_fifo:
  - Parameterised DEPTH and WIDTH.
  - Synchronous FIFO with push/pop/head/count.
  - Supports same-cycle push and pop.
  - Exposes count to the arbiter.

Test Plan:
- Both request reads, RR_EN=0, device grants every cycle: host 0 is granted first; host 1 is granted only after h0_req_i drops. rvalids return to host 0 with rdata 0xA5A5_0000_0000_0001, then to host 1 with 0x0000_0000_DEAD_BEEF.
- RR_EN=1, both request continuously, gnt held high: grants alternate 0,1,0,1 over 4 cycles, and d_addr_o alternates 0x1000/0x2000 accordingly.
- Host 0 requests 0x80 and gnt is held low for 3 cycles; host 1 asserts req in cycle 2: d_addr_o stays 0x80 for all 4 cycles. h1_gnt_o stays 0 until the cycle after host 0's grant.
- MAX_OUTSTANDING=2, three back-to-back reads with no rvalid: the first two are granted, the third sees d_req_o = 0. One rvalid arrives, and on the next cycle the third read is issued.
- Write from host 1 (we=1, be=0x0F) granted, then a read from host 0: count after the write = 0. The single rvalid goes to host 0 only.
- Unsolicited d_rvalid_i at reset idle: no host rvalid, rsp_err_o = 1 the next cycle. Asserting rst_i clears rsp_err_o to 0.
